// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared encodings for the BIU AHB master-port arbiter: AHB transfer and
// burst codes, the idle protection value and the arbiter state machine codes.
package ahb_bus_arbiter_pkg;

   // AHB HTRANS encodings
   typedef enum logic [1:0] {
      HTRANS_IDLE = 2'b00,
      HTRANS_BUSY = 2'b01,
      HTRANS_NSEQ = 2'b10,
      HTRANS_SEQ  = 2'b11
   } htrans_e;

   // AHB HBURST encodings used by the BIU requesters
   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001
   } hburst_e;

   // Protection presented while no requester owns the address phase
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   // Arbiter state machine
   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      GRANTED  = 2'b01,
      DRAIN    = 2'b10
   } arb_state_e;

   // A transfer that carries a data phase (NSEQ or SEQ) has HTRANS[1] set
   function automatic logic htrans_active(input logic [1:0] trans);
      return trans[1];
   endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin selector. Returns a one-hot grant for the first
// requester at or above ptr (wrapping), or requester 0 outright when hipri_en
// is set and requester 0 is requesting. valid flags that any request exists.
module ahb_bus_arbiter_rr_pick #(
   parameter int NM = 3,
   parameter int PW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic [NM-1:0] req,
   input  logic [PW-1:0] ptr,
   input  logic          hipri_en,
   output logic [NM-1:0] grant,
   output logic          valid
);

   logic          found;
   logic [PW-1:0] idx;

   // Scan requesters starting at ptr; the first one seen wins
   always_comb begin
      grant = {NM{1'b0}};
      found = 1'b0;
      idx   = {PW{1'b0}};
      if (hipri_en && req[0]) begin
         grant[0] = 1'b1;
      end else begin
         for (int k = 0; k < NM; k++) begin
            idx        = PW'((int'(ptr) + k) % NM);
            grant[idx] = grant[idx] | (req[idx] & ~found);
            found      = found | req[idx];
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Shares the single AHB master port of the CPU BIU among NM requesters.
// A grant is held for a whole transaction; after the owner releases, the bus
// passes through DRAIN until the last data phase completes, then re-arbitrates.
module ahb_bus_arbiter
   import ahb_bus_arbiter_pkg::*;
#(
   parameter int NM       = 3,
   parameter bit HIPRI_EN = 1'b1,
   parameter int AW       = 64,
   parameter int DW       = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NM-1:0]     m_bus_req,
   output logic [NM-1:0]     m_bus_ack,
   input  logic [NM*AW-1:0]  m_haddr,
   input  logic [NM-1:0]     m_hwrite,
   input  logic [NM*3-1:0]   m_hsize,
   input  logic [NM*3-1:0]   m_hburst,
   input  logic [NM*4-1:0]   m_hprot,
   input  logic [NM*2-1:0]   m_htrans,
   input  logic [NM-1:0]     m_hmastlock,
   input  logic [NM*DW-1:0]  m_hwdata,
   output logic [NM-1:0]     m_hresp,
   output logic [AW-1:0]     haddr,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [3:0]        hprot,
   output logic [1:0]        htrans,
   output logic              hmastlock,
   output logic [DW-1:0]     hwdata,
   input  logic              hready,
   input  logic              hresp
);

   localparam int PW = (NM > 1) ? $clog2(NM) : 1;

   arb_state_e    state_r;
   arb_state_e    state_n;
   logic [NM-1:0] ack_n;
   logic [PW-1:0] rr_ptr_r;
   logic [PW-1:0] rr_ptr_n;
   // One-hot data-phase owner; all zeros means no data phase in flight
   logic [NM-1:0] downer_r;
   logic [NM-1:0] downer_n;

   logic [NM-1:0] pick_grant;
   logic          pick_valid;
   logic [PW-1:0] win_idx;

   logic [AW-1:0] own_haddr;
   logic          own_hwrite;
   logic [2:0]    own_hsize;
   logic [2:0]    own_hburst;
   logic [3:0]    own_hprot;
   logic [1:0]    own_htrans;
   logic          own_hmastlock;
   logic          own_req;

   ahb_bus_arbiter_rr_pick #(
      .NM (NM),
      .PW (PW)
   ) u_rr_pick (
      .req      (m_bus_req),
      .ptr      (rr_ptr_r),
      .hipri_en (HIPRI_EN),
      .grant    (pick_grant),
      .valid    (pick_valid)
   );

   // Binary index of the selected winner, used to advance the pointer
   always_comb begin
      win_idx = {PW{1'b0}};
      for (int i = 0; i < NM; i++) begin
         win_idx = win_idx | (pick_grant[i] ? PW'(i) : {PW{1'b0}});
      end
   end

   // AND-OR mux of the address-phase signals of the current grant holder
   always_comb begin
      own_haddr     = {AW{1'b0}};
      own_hwrite    = 1'b0;
      own_hsize     = 3'b000;
      own_hburst    = 3'b000;
      own_hprot     = 4'b0000;
      own_htrans    = 2'b00;
      own_hmastlock = 1'b0;
      for (int i = 0; i < NM; i++) begin
         own_haddr     = own_haddr     | (m_haddr[i*AW +: AW] & {AW{m_bus_ack[i]}});
         own_hwrite    = own_hwrite    | (m_hwrite[i] & m_bus_ack[i]);
         own_hsize     = own_hsize     | (m_hsize[i*3 +: 3] & {3{m_bus_ack[i]}});
         own_hburst    = own_hburst    | (m_hburst[i*3 +: 3] & {3{m_bus_ack[i]}});
         own_hprot     = own_hprot     | (m_hprot[i*4 +: 4] & {4{m_bus_ack[i]}});
         own_htrans    = own_htrans    | (m_htrans[i*2 +: 2] & {2{m_bus_ack[i]}});
         own_hmastlock = own_hmastlock | (m_hmastlock[i] & m_bus_ack[i]);
      end
      own_req = |(m_bus_req & m_bus_ack);
   end

   // AHB address phase: owner's signals while GRANTED, idle values otherwise
   always_comb begin
      haddr     = {AW{1'b0}};
      hwrite    = 1'b0;
      hsize     = 3'b000;
      hburst    = HBURST_SINGLE;
      hprot     = HPROT_DEFAULT;
      htrans    = HTRANS_IDLE;
      hmastlock = 1'b0;
      if (state_r == GRANTED) begin
         haddr     = own_haddr;
         hwrite    = own_hwrite;
         hsize     = own_hsize;
         hburst    = own_hburst;
         hprot     = own_hprot;
         htrans    = own_htrans;
         hmastlock = own_hmastlock;
      end else begin
         htrans    = HTRANS_IDLE;
      end
   end

   // Write data follows the data-phase owner, zero when no data phase
   always_comb begin
      hwdata = {DW{1'b0}};
      for (int i = 0; i < NM; i++) begin
         hwdata = hwdata | (m_hwdata[i*DW +: DW] & {DW{downer_r[i]}});
      end
   end

   // Error response only reaches the requester owning the data phase
   assign m_hresp = {NM{hresp}} & downer_r;

   // Data-phase owner advances on each accepted transfer, holds in wait states
   always_comb begin
      downer_n = downer_r;
      if (hready) begin
         if (htrans_active(htrans)) begin
            downer_n = m_bus_ack;
         end else begin
            downer_n = {NM{1'b0}};
         end
      end else begin
         downer_n = downer_r;
      end
   end

   // Arbiter next state, next grant and next round-robin pointer
   always_comb begin
      state_n  = state_r;
      ack_n    = m_bus_ack;
      rr_ptr_n = rr_ptr_r;
      case (state_r)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_n  = GRANTED;
               ack_n    = pick_grant;
               rr_ptr_n = (win_idx == PW'(NM - 1)) ? {PW{1'b0}} : (win_idx + PW'(1));
            end else begin
               state_n  = ARB_IDLE;
               ack_n    = {NM{1'b0}};
            end
         end
         GRANTED: begin
            // Hold through the whole transaction, even after the request drops
            if (!own_req && (own_htrans == HTRANS_IDLE)) begin
               state_n = DRAIN;
               ack_n   = {NM{1'b0}};
            end else begin
               state_n = GRANTED;
            end
         end
         DRAIN: begin
            ack_n = {NM{1'b0}};
            if (hready && (downer_r == {NM{1'b0}})) begin
               state_n = ARB_IDLE;
            end else begin
               state_n = DRAIN;
            end
         end
         default: begin
            state_n  = ARB_IDLE;
            ack_n    = {NM{1'b0}};
            rr_ptr_n = {PW{1'b0}};
         end
      endcase
   end

   // State, grant, pointer and data-phase owner registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ARB_IDLE;
         m_bus_ack <= {NM{1'b0}};
         rr_ptr_r  <= {PW{1'b0}};
         downer_r  <= {NM{1'b0}};
      end else begin
         state_r   <= state_n;
         m_bus_ack <= ack_n;
         rr_ptr_r  <= rr_ptr_n;
         downer_r  <= downer_n;
      end
   end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a per-cycle vector table for arbitration,
// error routing and priority, plus hand sequences for the long burst, the
// write wait-state drain and an asynchronous reset mid-burst.
`timescale 1ns/1ps
module tb_ahb_bus_arbiter;
   import ahb_bus_arbiter_pkg::*;

   localparam int NM = 3;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam logic [63:0] A0 = 64'h0000_0000_0000_A000;
   localparam logic [63:0] A1 = 64'h0000_0000_0000_B000;
   localparam logic [63:0] A2 = 64'h0000_0000_0000_C000;
   localparam logic [63:0] WDATA = 64'hDEADBEEF_00000001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NM-1:0]    m_bus_req;
   logic [NM*AW-1:0] m_haddr;
   logic [NM-1:0]    m_hwrite;
   logic [NM*3-1:0]  m_hsize;
   logic [NM*3-1:0]  m_hburst;
   logic [NM*4-1:0]  m_hprot;
   logic [NM*2-1:0]  m_htrans;
   logic [NM-1:0]    m_hmastlock;
   logic [NM*DW-1:0] m_hwdata;
   logic             hready;
   logic             hresp;

   logic [NM-1:0] ack,  rsp;
   logic [AW-1:0] haddr;
   logic          hwrite, hmastlock;
   logic [2:0]    hsize, hburst;
   logic [3:0]    hprot;
   logic [1:0]    htrans;
   logic [DW-1:0] hwdata;

   logic [NM-1:0] rr_ack, rr_rsp;
   logic [AW-1:0] rr_haddr;
   logic          rr_hwrite, rr_hmastlock;
   logic [2:0]    rr_hsize, rr_hburst;
   logic [3:0]    rr_hprot;
   logic [1:0]    rr_htrans;
   logic [DW-1:0] rr_hwdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ahb_bus_arbiter #(.NM(NM), .HIPRI_EN(1'b1), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .m_bus_req(m_bus_req), .m_bus_ack(ack),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
      .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hmastlock(m_hmastlock),
      .m_hwdata(m_hwdata), .m_hresp(rsp), .haddr(haddr), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
      .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready), .hresp(hresp)
   );

   ahb_bus_arbiter #(.NM(NM), .HIPRI_EN(1'b0), .AW(AW), .DW(DW)) u_rr (
      .clk(clk), .rst_n(rst_n), .m_bus_req(m_bus_req), .m_bus_ack(rr_ack),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
      .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hmastlock(m_hmastlock),
      .m_hwdata(m_hwdata), .m_hresp(rr_rsp), .haddr(rr_haddr), .hwrite(rr_hwrite),
      .hsize(rr_hsize), .hburst(rr_hburst), .hprot(rr_hprot), .htrans(rr_htrans),
      .hmastlock(rr_hmastlock), .hwdata(rr_hwdata), .hready(hready), .hresp(hresp)
   );

   typedef struct {
      logic [2:0]  req;
      logic [5:0]  trans;
      logic        rdy;
      logic        err;
      logic [2:0]  ack;
      logic [2:0]  rr_ack;
      logic [1:0]  htr;
      logic [63:0] addr;
      logic [2:0]  resp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] req, input logic [5:0] trans, input logic rdy,
                      input logic err, input logic [2:0] a, input logic [2:0] ra,
                      input logic [1:0] htr, input logic [63:0] addr, input logic [2:0] resp);
      vec_t v;
      v.req = req; v.trans = trans; v.rdy = rdy; v.err = err; v.ack = a;
      v.rr_ack = ra; v.htr = htr; v.addr = addr; v.resp = resp;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      m_bus_req = 3'b000;
      m_htrans  = 6'b000000;
      hready    = 1'b1;
      hresp     = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      m_bus_req   = 3'b111;
      m_haddr     = {A2, A1, A0};
      m_hwrite    = 3'b000;
      m_hsize     = 9'b010_010_010;
      m_hburst    = 9'b000_000_000;
      m_hprot     = 12'hFFF;
      m_htrans    = 6'b101010;
      m_hmastlock = 3'b111;
      m_hwdata    = {64'h2222, 64'h1111, 64'h0000};
      hready      = 1'b1;
      hresp       = 1'b1;

      // Reset state, with every requester active and hresp high
      @(posedge clk);
      @(negedge clk);
      check("rst ack", 64'(ack), 64'h0);
      check("rst htrans", 64'(htrans), 64'(HTRANS_IDLE));
      check("rst haddr", haddr, 64'h0);
      check("rst hwrite", 64'(hwrite), 64'h0);
      check("rst hsize", 64'(hsize), 64'h0);
      check("rst hburst", 64'(hburst), 64'h0);
      check("rst hprot", 64'(hprot), 64'h3);
      check("rst hmastlock", 64'(hmastlock), 64'h0);
      check("rst hwdata", hwdata, 64'h0);
      check("rst m_hresp", 64'(rsp), 64'h0);
      check("rst state", 64'(dut.state_r), 64'(ARB_IDLE));
      check("rst rr_ptr", 64'(dut.rr_ptr_r), 64'h0);
      m_hprot = 12'h000;
      m_hmastlock = 3'b000;
      do_reset();

      // req, trans{t2,t1,t0}, hready, hresp, ack, rr_ack, htrans, haddr, m_hresp
      add(3'b110, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b110, 6'b001000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b10, A1,    3'b000);
      add(3'b100, 6'b000000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b00, A1,    3'b000);
      add(3'b100, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b100, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b100, 6'b100000, 1'b1, 1'b0, 3'b100, 3'b100, 2'b10, A2,    3'b000);
      add(3'b010, 6'b000000, 1'b1, 1'b0, 3'b100, 3'b100, 2'b00, A2,    3'b000);
      add(3'b110, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b110, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b110, 6'b001000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b10, A1,    3'b000);
      add(3'b100, 6'b000000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b00, A1,    3'b000);
      add(3'b100, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b100, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b100, 6'b100000, 1'b1, 1'b0, 3'b100, 3'b100, 2'b10, A2,    3'b000);
      add(3'b000, 6'b000000, 1'b1, 1'b0, 3'b100, 3'b100, 2'b00, A2,    3'b000);
      add(3'b000, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      // error response during requester 1's data phase
      add(3'b010, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b010, 6'b001000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b10, A1,    3'b000);
      add(3'b010, 6'b000000, 1'b0, 1'b1, 3'b010, 3'b010, 2'b00, A1,    3'b010);
      add(3'b010, 6'b000000, 1'b1, 1'b1, 3'b010, 3'b010, 2'b00, A1,    3'b010);
      add(3'b010, 6'b000000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b00, A1,    3'b000);
      add(3'b000, 6'b000000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b00, A1,    3'b000);
      add(3'b000, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b000, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      // requester 0 arrives mid-burst of requester 1, requester 2 pending
      add(3'b010, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b010, 6'b001000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b10, A1,    3'b000);
      add(3'b111, 6'b001100, 1'b1, 1'b0, 3'b010, 3'b010, 2'b11, A1,    3'b000);
      add(3'b101, 6'b001100, 1'b1, 1'b0, 3'b010, 3'b010, 2'b11, A1,    3'b000);
      add(3'b101, 6'b000000, 1'b1, 1'b0, 3'b010, 3'b010, 2'b00, A1,    3'b000);
      add(3'b101, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b101, 6'b000000, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 64'h0, 3'b000);
      add(3'b101, 6'b000010, 1'b1, 1'b0, 3'b001, 3'b100, 2'b10, A0,    3'b000);

      for (int r = 0; r < vecs.size(); r++) begin
         @(posedge clk);
         #1;
         m_bus_req = vecs[r].req;
         m_htrans  = vecs[r].trans;
         hready    = vecs[r].rdy;
         hresp     = vecs[r].err;
         @(negedge clk);
         check($sformatf("vec%0d ack", r), 64'(ack), 64'(vecs[r].ack));
         check($sformatf("vec%0d rr ack", r), 64'(rr_ack), 64'(vecs[r].rr_ack));
         check($sformatf("vec%0d htrans", r), 64'(htrans), 64'(vecs[r].htr));
         check($sformatf("vec%0d haddr", r), haddr, vecs[r].addr);
         check($sformatf("vec%0d m_hresp", r), 64'(rsp), 64'(vecs[r].resp));
      end

      // 256-beat INCR read burst from the D-cache (requester 2)
      do_reset();
      m_hburst[8:6] = HBURST_INCR;
      m_hsize[8:6]  = 3'b011;
      @(posedge clk);
      #1;
      m_bus_req = 3'b100;
      @(negedge clk);
      check("burst ack before grant", 64'(ack), 64'h0);
      for (int b = 0; b < 256; b++) begin
         @(posedge clk);
         #1;
         m_htrans[5:4]       = (b == 0) ? HTRANS_NSEQ : HTRANS_SEQ;
         m_haddr[128 +: 64]  = 64'h0000_0000_8000_0000 + 64'(b) * 64'd8;
         @(negedge clk);
         if (b == 0 || b == 255) begin
            check($sformatf("burst beat%0d ack", b), 64'(ack), 64'h4);
            check($sformatf("burst beat%0d hburst", b), 64'(hburst), 64'(HBURST_INCR));
            check($sformatf("burst beat%0d hsize", b), 64'(hsize), 64'h3);
         end
         check($sformatf("burst beat%0d htrans", b), 64'(htrans),
               (b == 0) ? 64'(HTRANS_NSEQ) : 64'(HTRANS_SEQ));
         check($sformatf("burst beat%0d haddr", b), haddr,
               64'h0000_0000_8000_0000 + 64'(b) * 64'd8);
      end
      @(posedge clk);
      #1;
      m_bus_req = 3'b000;
      m_htrans  = 6'b000000;
      @(negedge clk);
      check("burst end ack held", 64'(ack), 64'h4);
      check("burst end htrans", 64'(htrans), 64'(HTRANS_IDLE));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("burst drain state", 64'(dut.state_r), 64'(DRAIN));
      check("burst drain ack", 64'(ack), 64'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("burst idle state", 64'(dut.state_r), 64'(ARB_IDLE));
      m_haddr = {A2, A1, A0};

      // Single write from requester 2 with a 3-cycle wait state in its data phase
      do_reset();
      m_hwdata[128 +: 64] = WDATA;
      m_hwrite[2] = 1'b1;
      @(posedge clk);
      #1;
      m_bus_req = 3'b100;
      @(posedge clk);
      #1;
      m_htrans[5:4] = HTRANS_NSEQ;
      @(negedge clk);
      check("wr htrans", 64'(htrans), 64'(HTRANS_NSEQ));
      check("wr hwrite", 64'(hwrite), 64'h1);
      for (int s = 0; s < 3; s++) begin
         @(posedge clk);
         #1;
         m_bus_req = 3'b000;
         m_htrans  = 6'b000000;
         hready    = 1'b0;
         @(negedge clk);
         check($sformatf("wr stall%0d hwdata", s), hwdata, WDATA);
         check($sformatf("wr stall%0d state", s), 64'(dut.state_r),
               (s == 0) ? 64'(GRANTED) : 64'(DRAIN));
      end
      @(posedge clk);
      #1;
      hready = 1'b1;
      @(negedge clk);
      check("wr last beat hwdata", hwdata, WDATA);
      check("wr last beat state", 64'(dut.state_r), 64'(DRAIN));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("wr post hwdata", hwdata, 64'h0);
      check("wr post state", 64'(dut.state_r), 64'(DRAIN));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("wr idle state", 64'(dut.state_r), 64'(ARB_IDLE));
      m_hwrite[2] = 1'b0;

      // Asynchronous reset in the middle of a requester 1 burst
      do_reset();
      @(posedge clk);
      #1;
      m_bus_req = 3'b010;
      @(posedge clk);
      #1;
      m_htrans[3:2] = HTRANS_NSEQ;
      @(posedge clk);
      #1;
      m_htrans[3:2] = HTRANS_SEQ;
      @(negedge clk);
      check("arst ack before", 64'(ack), 64'h2);
      check("arst ptr before", 64'(dut.rr_ptr_r), 64'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst ack", 64'(ack), 64'h0);
      check("arst rr ack", 64'(rr_ack), 64'h0);
      check("arst htrans", 64'(htrans), 64'(HTRANS_IDLE));
      m_bus_req = 3'b110;
      m_htrans  = 6'b000000;
      @(negedge clk);
      rst_n = 1'b1;
      check("arst ptr after", 64'(dut.rr_ptr_r), 64'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("arst regrant", 64'(ack), 64'h2);
      check("arst rr regrant", 64'(rr_ack), 64'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
